// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the two-bank packet scheduler.
// Holds the bank/FSM encodings, the slot command set and the length clamp.
package pkt_sched_pkg;

  localparam int BANK_BYTES_DEF = 2048;  // 64 BRAM words x 32 B

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FULL     = 2'd1,
    BANK_DRAINING = 2'd2
  } bank_state_e;

  typedef enum logic {
    FE_WRITE = 1'b0,
    FE_WAIT  = 1'b1
  } fe_state_e;

  typedef enum logic {
    BE_IDLE = 1'b0,
    BE_BUSY = 1'b1
  } be_state_e;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_FILL  = 2'd1,
    SLOT_DRAIN = 2'd2,
    SLOT_FREE  = 2'd3
  } slot_cmd_e;

  function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] cap);
    return (len > cap) ? cap : len;
  endfunction

endpackage

// File: rtl/pkt_bank_slot.sv
// One ping-pong bank: its EMPTY/FULL/DRAINING state and the latched packet length.
// Commands come from the scheduler; the scheduler guarantees at most one per cycle.
module pkt_bank_slot
  import pkt_sched_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  slot_cmd_e   cmd,
  input  logic [15:0] len_in,
  output bank_state_e state,
  output logic [15:0] len
);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= BANK_EMPTY;
      // NOTE: the length is reset too, so a discarded packet leaves nothing behind.
      len   <= '0;
    end else begin
      unique case (cmd)
        SLOT_FILL: begin
          state <= BANK_FULL;
          len   <= len_in;
        end
        SLOT_DRAIN: state <= BANK_DRAINING;
        SLOT_FREE:  state <= BANK_EMPTY;
        default:    ;
      endcase
    end
  end

endmodule

// File: rtl/pkt_bank_sched.sv
// Two-bank packet scheduler: frontend fills one bank while the backend drains the other.
// Frontend and backend FSMs share only the registered per-bank state.
module pkt_bank_sched
  import pkt_sched_pkg::*;
#(
  parameter int BANK_BYTES = BANK_BYTES_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             fe_start,
  input  logic [15:0]      fe_length,
  output logic             fe_finish,
  output logic             fe_bank,
  output logic             be_start,
  output logic [15:0]      be_length,
  output logic             be_bank,
  input  logic             be_finish,
  output logic [1:0]       bank_full,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             err
);

  localparam logic [15:0] LEN_CAP = 16'(BANK_BYTES);

  bank_state_e      slot_state [2];
  logic [15:0]      slot_len   [2];
  slot_cmd_e        slot_cmd   [2];

  fe_state_e        fe_state, fe_state_n;
  be_state_e        be_state, be_state_n;
  logic             fe_finish_n, fe_bank_n, fill, other_empty, len_bad;
  logic             be_start_n, be_bank_n, rd, rd_n, drain, release_bank, err_n;
  logic [15:0]      be_length_n;
  logic [CNT_W-1:0] pkt_cnt_n;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    pkt_bank_slot u_slot (
      .aclk    (aclk),
      .aresetn (aresetn),
      .cmd     (slot_cmd[i]),
      .len_in  (clamp_len(fe_length, LEN_CAP)),
      .state   (slot_state[i]),
      .len     (slot_len[i])
    );
    assign bank_full[i] = (slot_state[i] != BANK_EMPTY);
  end

  assign other_empty = (slot_state[~fe_bank] == BANK_EMPTY);
  assign len_bad     = (fe_length == 16'd0) || (fe_length > LEN_CAP);

  // NOTE: defaults first keep this block latch-free on every path.
  always_comb begin
    fe_state_n  = fe_state;
    fe_finish_n = 1'b0;
    fe_bank_n   = fe_bank;
    fill        = 1'b0;
    case (fe_state)
      FE_WRITE: if (fe_start) begin
        fill = 1'b1;
        if (other_empty) begin
          fe_finish_n = 1'b1;
          fe_bank_n   = ~fe_bank;
        end else begin
          fe_state_n = FE_WAIT;
        end
      end
      FE_WAIT: if (other_empty) begin
        fe_finish_n = 1'b1;
        fe_bank_n   = ~fe_bank;
        fe_state_n  = FE_WRITE;
      end
    endcase
  end

  always_comb begin
    be_state_n   = be_state;
    rd_n         = rd;
    be_start_n   = 1'b0;
    be_bank_n    = be_bank;
    be_length_n  = be_length;
    pkt_cnt_n    = pkt_cnt;
    drain        = 1'b0;
    release_bank = 1'b0;
    case (be_state)
      BE_IDLE: if (slot_state[rd] == BANK_FULL) begin
        drain       = 1'b1;
        be_start_n  = 1'b1;
        be_bank_n   = rd;
        be_length_n = slot_len[rd];
        pkt_cnt_n   = pkt_cnt + CNT_W'(1);
        be_state_n  = BE_BUSY;
      end
      BE_BUSY: if (be_finish) begin
        release_bank = 1'b1;
        rd_n         = ~rd;
        be_state_n   = BE_IDLE;
      end
    endcase
  end

  // The filled bank is always EMPTY and the drained/released one never is, so they never collide.
  always_comb begin
    for (int i = 0; i < 2; i++) slot_cmd[i] = SLOT_HOLD;
    if (fill)              slot_cmd[fe_bank] = SLOT_FILL;
    if (drain)             slot_cmd[rd]      = SLOT_DRAIN;
    else if (release_bank) slot_cmd[rd]      = SLOT_FREE;
  end

  assign err_n = err
               | (fe_start && ((fe_state == FE_WAIT) || len_bad))
               | (be_finish && (be_state == BE_IDLE));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      fe_state  <= FE_WRITE;
      fe_finish <= 1'b0;
      fe_bank   <= 1'b0;
      be_state  <= BE_IDLE;
      rd        <= 1'b0;
      be_start  <= 1'b0;
      be_bank   <= 1'b0;
      be_length <= '0;
      pkt_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      fe_state  <= fe_state_n;
      fe_finish <= fe_finish_n;
      fe_bank   <= fe_bank_n;
      be_state  <= be_state_n;
      rd        <= rd_n;
      be_start  <= be_start_n;
      be_bank   <= be_bank_n;
      be_length <= be_length_n;
      pkt_cnt   <= pkt_cnt_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_pkt_bank_sched.sv
// Bench for pkt_bank_sched: directed vector table, hand sequences for reset/wrap,
// and random traffic checked against a packet-count model of the two banks.
module tb_pkt_bank_sched;

  localparam int CNT_W      = 8;  // small counter so the wrap sequence stays short
  localparam int BANK_BYTES = 2048;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             fe_start = 1'b0;
  logic [15:0]      fe_length = '0;
  logic             be_finish = 1'b0;
  logic             fe_finish, fe_bank, be_start, be_bank, err;
  logic [15:0]      be_length;
  logic [1:0]       bank_full;
  logic [CNT_W-1:0] pkt_cnt;

  pkt_bank_sched #(.BANK_BYTES(BANK_BYTES), .CNT_W(CNT_W)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .fe_start  (fe_start),
    .fe_length (fe_length),
    .fe_finish (fe_finish),
    .fe_bank   (fe_bank),
    .be_start  (be_start),
    .be_length (be_length),
    .be_bank   (be_bank),
    .be_finish (be_finish),
    .bank_full (bank_full),
    .pkt_cnt   (pkt_cnt),
    .err       (err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_ff, input logic e_fb,
                            input logic e_bs, input logic e_bb, input logic [15:0] e_bl,
                            input logic [1:0] e_full, input logic [CNT_W-1:0] e_cnt,
                            input logic e_er);
    check({tag, ".fe_finish"}, 32'(fe_finish), 32'(e_ff));
    check({tag, ".fe_bank"},   32'(fe_bank),   32'(e_fb));
    check({tag, ".be_start"},  32'(be_start),  32'(e_bs));
    check({tag, ".be_bank"},   32'(be_bank),   32'(e_bb));
    check({tag, ".be_length"}, 32'(be_length), 32'(e_bl));
    check({tag, ".bank_full"}, 32'(bank_full), 32'(e_full));
    check({tag, ".pkt_cnt"},   32'(pkt_cnt),   32'(e_cnt));
    check({tag, ".err"},       32'(err),       32'(e_er));
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic fs, input logic [15:0] fl, input logic bf);
    aresetn   = !rst;
    fe_start  = fs;
    fe_length = fl;
    be_finish = bf;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             rst, fs, bf;
    logic [15:0]      fl;
    logic             ff, fb, bs, bb;
    logic [15:0]      bl;
    logic [1:0]       full;
    logic [CNT_W-1:0] cnt;
    logic             er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic fs, input int fl, input logic bf,
                     input logic ff, input logic fb, input logic bs, input logic bb,
                     input int bl, input logic [1:0] full, input int cnt, input logic er);
    vec_t v;
    v.rst = rst; v.fs = fs; v.fl = 16'(fl); v.bf = bf;
    v.ff = ff; v.fb = fb; v.bs = bs; v.bb = bb; v.bl = 16'(bl);
    v.full = full; v.cnt = CNT_W'(cnt); v.er = er;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Banks are a two-entry ring: the k-th accepted packet lives in bank k%2.
  int unsigned m_acc, m_grants, m_started, m_finished;
  logic [15:0] m_q[$];
  logic        m_err, m_ff, m_bs, m_bb;
  logic [15:0] m_bl;

  task automatic model_reset();
    m_acc = 0; m_grants = 0; m_started = 0; m_finished = 0;
    m_q.delete();
    m_err = 1'b0; m_ff = 1'b0; m_bs = 1'b0; m_bb = 1'b0; m_bl = '0;
  endtask

  function automatic bit model_waiting();
    return m_acc != m_grants;
  endfunction

  function automatic bit model_busy();
    return m_started != m_finished;
  endfunction

  task automatic model_step(input logic fs, input logic [15:0] fl, input logic bf);
    int unsigned acc0 = m_acc;
    int unsigned occ  = m_acc - m_finished;
    bit          wait0 = model_waiting();
    m_ff = 1'b0;
    m_bs = 1'b0;
    if (!model_busy()) begin
      if (bf) m_err = 1'b1;
      if (m_started < acc0) begin
        m_bl = m_q.pop_front();
        m_bb = m_started[0];
        m_started++;
        m_bs = 1'b1;
      end
    end else if (bf) begin
      m_finished++;
    end
    if (!wait0) begin
      if (fs) begin
        if (fl == 0 || fl > BANK_BYTES) m_err = 1'b1;
        m_q.push_back((fl > BANK_BYTES) ? 16'(BANK_BYTES) : fl);
        m_acc++;
        if (occ == 0) begin m_grants++; m_ff = 1'b1; end
      end
    end else begin
      if (fs) m_err = 1'b1;
      if (occ == 1) begin m_grants++; m_ff = 1'b1; end
    end
  endtask

  task automatic model_check(input string tag);
    int unsigned occ = m_acc - m_finished;
    logic [1:0]  full;
    if (occ >= 2)      full = 2'b11;
    else if (occ == 1) full = m_finished[0] ? 2'b10 : 2'b01;
    else               full = 2'b00;
    check_outs(tag, m_ff, m_grants[0], m_bs, m_bb, m_bl, full, CNT_W'(m_started), m_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst fs  fl    bf | ff fb bs bb  bl    full  cnt er
    add(1, 0, 0,    0,   0, 0, 0, 0, 0,    2'b00, 0, 0);
    // single packet, back-pressure, simultaneous fe_start/be_finish
    add(0, 1, 1514, 0,   1, 1, 0, 0, 0,    2'b01, 0, 0);
    add(0, 0, 0,    0,   0, 1, 1, 0, 1514, 2'b01, 1, 0);
    add(0, 1, 60,   0,   0, 1, 0, 0, 1514, 2'b11, 1, 0);
    add(0, 0, 0,    0,   0, 1, 0, 0, 1514, 2'b11, 1, 0);
    add(0, 0, 0,    1,   0, 1, 0, 0, 1514, 2'b10, 1, 0);
    add(0, 0, 0,    0,   1, 0, 1, 1, 60,   2'b10, 2, 0);
    add(0, 1, 42,   0,   0, 0, 0, 1, 60,   2'b11, 2, 0);
    add(0, 0, 0,    1,   0, 0, 0, 1, 60,   2'b01, 2, 0);
    add(0, 0, 0,    0,   1, 1, 1, 0, 42,   2'b01, 3, 0);
    add(0, 1, 100,  1,   0, 1, 0, 0, 42,   2'b10, 3, 0);
    add(0, 0, 0,    0,   1, 0, 1, 1, 100,  2'b10, 4, 0);
    add(0, 0, 0,    1,   0, 0, 0, 1, 100,  2'b00, 4, 0);
    add(0, 0, 0,    0,   0, 0, 0, 1, 100,  2'b00, 4, 0);
    add(0, 0, 0,    1,   0, 0, 0, 1, 100,  2'b00, 4, 1);  // be_finish while idle
    // fe_start while waiting is dropped
    add(1, 0, 0,    0,   0, 0, 0, 0, 0,    2'b00, 0, 0);
    add(0, 1, 10,   0,   1, 1, 0, 0, 0,    2'b01, 0, 0);
    add(0, 0, 0,    0,   0, 1, 1, 0, 10,   2'b01, 1, 0);
    add(0, 1, 20,   0,   0, 1, 0, 0, 10,   2'b11, 1, 0);
    add(0, 1, 7,    0,   0, 1, 0, 0, 10,   2'b11, 1, 1);
    add(0, 0, 0,    1,   0, 1, 0, 0, 10,   2'b10, 1, 1);
    add(0, 0, 0,    0,   1, 0, 1, 1, 20,   2'b10, 2, 1);
    // oversize length saturates
    add(1, 0, 0,    0,   0, 0, 0, 0, 0,    2'b00, 0, 0);
    add(0, 1, 100,  0,   1, 1, 0, 0, 0,    2'b01, 0, 0);
    add(0, 0, 0,    0,   0, 1, 1, 0, 100,  2'b01, 1, 0);
    add(0, 0, 0,    1,   0, 1, 0, 0, 100,  2'b00, 1, 0);
    add(0, 1, 3000, 0,   1, 0, 0, 0, 100,  2'b10, 1, 1);
    add(0, 0, 0,    0,   0, 0, 1, 1, 2048, 2'b10, 2, 1);
    // exact capacity is legal, zero is flagged but forwarded
    add(1, 0, 0,    0,   0, 0, 0, 0, 0,    2'b00, 0, 0);
    add(0, 1, 2048, 0,   1, 1, 0, 0, 0,    2'b01, 0, 0);
    add(0, 0, 0,    0,   0, 1, 1, 0, 2048, 2'b01, 1, 0);
    add(0, 0, 0,    1,   0, 1, 0, 0, 2048, 2'b00, 1, 0);
    add(0, 1, 0,    0,   1, 0, 0, 0, 2048, 2'b10, 1, 1);
    add(0, 0, 0,    0,   0, 0, 1, 1, 0,    2'b10, 2, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].fs, tbl[i].fl, tbl[i].bf);
      step();
      check_outs($sformatf("vec%0d", i), tbl[i].ff, tbl[i].fb, tbl[i].bs, tbl[i].bb,
                 tbl[i].bl, tbl[i].full, tbl[i].cnt, tbl[i].er);
    end

    // reset with both banks occupied discards them
    drive(1, 0, 0, 0); step();
    drive(0, 1, 10, 0); step();
    drive(0, 1, 20, 0); step();
    drive(0, 0, 0, 0);
    check("rst_mid.bank_full_before", 32'(bank_full), 32'h3);
    drive(1, 0, 0, 0); step();
    check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'b00, '0, 1'b0);
    drive(0, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("rst_mid.idle%0d.be_start", c), 32'(be_start), 32'h0);
      check($sformatf("rst_mid.idle%0d.fe_finish", c), 32'(fe_finish), 32'h0);
      check($sformatf("rst_mid.idle%0d.bank_full", c), 32'(bank_full), 32'h0);
    end

    // pkt_cnt wrap over 2^CNT_W + 1 packets
    drive(1, 0, 0, 0); step();
    for (int n = 0; n <= (1 << CNT_W); n++) begin
      drive(0, 1, 64, 0); step();
      drive(0, 0, 0, 0);  step();
      if (n == (1 << CNT_W) - 1) check("wrap.zero", 32'(pkt_cnt), 32'h0);
      drive(0, 0, 0, 1);  step();
    end
    drive(0, 0, 0, 0); step();
    check("wrap.one", 32'(pkt_cnt), 32'h1);
    check("wrap.err", 32'(err), 32'h0);

    // random traffic in episodes, protocol slips kept rare so err stays informative
    for (int ep = 0; ep < 16; ep++) begin
      logic        fs, bf;
      logic [15:0] fl;
      drive(1, 0, 0, 0); step();
      model_reset();
      model_check($sformatf("rnd%0d.reset", ep));
      for (int c = 0; c < 250; c++) begin
        fs = model_waiting() ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 2) == 0);
        bf = model_busy()    ? ($urandom_range(0, 1) == 0)  : ($urandom_range(0, 59) == 0);
        case ($urandom_range(0, 39))
          0:       fl = 16'd0;
          1:       fl = 16'($urandom_range(BANK_BYTES + 1, 65535));
          default: fl = 16'($urandom_range(1, BANK_BYTES));
        endcase
        drive(0, fs, fl, bf);
        step();
        model_step(fs, fl, bf);
        model_check($sformatf("rnd%0d.c%0d", ep, c));
      end
    end

    drive(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_bank_sched.md
PKT_BANK_SCHED -- requirements
Module: pkt_bank_sched

Interface
REQ-001 SHALL have parameter BANK_BYTES, default 2048, per-bank capacity in bytes (64 BRAM words x 32 B).
REQ-002 SHALL have parameter CNT_W, default 16, width of the packet counter.
REQ-003 SHALL have port aclk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port fe_start  input  1  frontend one-cycle pulse: current write bank holds a complete packet.
REQ-006 SHALL have port fe_length  input  16  packet byte length, qualified by fe_start.
REQ-007 SHALL have port fe_finish  output  1  one-cycle pulse: a free bank is granted to the frontend.
REQ-008 SHALL have port fe_bank  output  1  bank the frontend writes (BRAM address MSB).
REQ-009 SHALL have port be_start  output  1  one-cycle pulse: backend may process be_bank.
REQ-010 SHALL have port be_length  output  16  byte length for be_bank, stable from be_start until be_finish.
REQ-011 SHALL have port be_bank  output  1  bank the backend reads.
REQ-012 SHALL have port be_finish  input  1  backend one-cycle pulse: be_bank fully consumed.
REQ-013 SHALL have port bank_full  output  2  per-bank FULL-or-DRAINING flag.
REQ-014 SHALL have port pkt_cnt  output  CNT_W  count of be_start pulses, wraps modulo 2^CNT_W.
REQ-015 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-016 Each bank SHALL hold state EMPTY, FULL or DRAINING plus a registered 16-bit length.
REQ-017 Frontend FSM SHALL have states FE_WRITE and FE_WAIT; on fe_start in FE_WRITE, bank fe_bank SHALL become FULL with fe_length latched.
REQ-018 In the cycle after that fe_start, if the other bank is EMPTY, fe_finish SHALL pulse and fe_bank SHALL toggle; otherwise FSM SHALL enter FE_WAIT.
REQ-019 In FE_WAIT, fe_finish SHALL pulse and fe_bank SHALL toggle one cycle after the other bank's registered state becomes EMPTY; FSM then returns to FE_WRITE.
REQ-020 Backend FSM SHALL have states BE_IDLE and BE_BUSY; a read pointer SHALL select the oldest FULL bank (strict alternation).
REQ-021 In BE_IDLE with bank[rd] FULL, be_start SHALL pulse for one cycle with be_bank=rd and be_length=stored length; bank becomes DRAINING; FSM goes BE_BUSY.
REQ-022 Latency fe_start -> be_start SHALL be 2 cycles when the backend is idle.
REQ-023 On be_finish in BE_BUSY, bank[rd] SHALL become EMPTY, rd SHALL toggle, FSM SHALL return to BE_IDLE; next be_start no earlier than the following cycle.
REQ-024 fe_start and be_finish in the same cycle SHALL both take effect; neither SHALL be lost.
REQ-025 fe_start in FE_WAIT SHALL be ignored and set err; be_finish in BE_IDLE SHALL be ignored and set err.
REQ-026 fe_length of 0 or > BANK_BYTES SHALL set err; 0 SHALL be forwarded unchanged, > BANK_BYTES SHALL saturate to BANK_BYTES.
REQ-027 pkt_cnt SHALL increment on every be_start, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-028 While aresetn=0 at a clock edge: both banks EMPTY, lengths 0, fe_bank=0, rd=0, FE_WRITE, BE_IDLE, fe_finish=0, be_start=0, be_length=0, be_bank=0, bank_full=0, pkt_cnt=0, err=0.
REQ-029 Reset mid-packet SHALL discard all bank contents; no be_start or fe_finish SHALL be issued for pre-reset packets.

Structure
REQ-030 FSM state encodings, bank-state encoding and the BANK_BYTES default SHALL live in a shared package pkt_sched_pkg.
REQ-031 Per-bank state and length storage SHALL be a sub-module pkt_bank_slot, instantiated twice.

Verification
REQ-032 Single packet: fe_start, fe_length=1514 at cycle 0 -> fe_finish at cycle 1 with fe_bank=1; be_start at cycle 2, be_bank=0, be_length=1514, pkt_cnt=1.
REQ-033 Back-pressure: two fe_start (60, 42) with no be_finish -> second fe_start leads to FE_WAIT, no fe_finish; be_finish -> fe_finish one cycle after bank 0 EMPTY, then be_start with be_bank=1, be_length=42.
REQ-034 Simultaneous: fe_start and be_finish on the same edge -> both banks' states correct; no lost packet; pkt_cnt tracks exactly.
REQ-035 Errors: be_finish in BE_IDLE -> err=1, no state change; fe_length=3000 -> be_length=2048, err=1.
REQ-036 Wrap and reset: 2^16+1 packets -> pkt_cnt=1; aresetn=0 with both banks FULL -> all outputs at reset values, no subsequent be_start.
